sram_rw_arbiter: RTL and testbench

Single-port SRAM front-end for the 1024x512 data-array macros (one RW port, one-cycle registered read). It arbitrates one read requester and one write requester onto the single RW port with write priority and a bounded-starvation guarantee for reads. It returns read data with a fixed latency and holds it stable between responses. Optionally it zero-fills the array after reset. It sits between the cache pipeline/refill unit and the SRAM macro.

---
 rtl/sram_rw_arbiter_if.sv | 49 ++++
 rtl/sram_rw_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_rw_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rw_arbiter_if.sv
// sram_rw_arbiter_if: request, response and macro-side signals of the SRAM RW-port arbiter.
// The arbiter takes the slave view; the requesters, the macro and the bench take the master view.
interface sram_rw_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 512
);
    // Read requester
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;

    // Write requester
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;

    // SRAM macro
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    // Status
    logic              init_done;

    modport slave (
        input  rd_req_valid, rd_req_addr,
        input  wr_req_valid, wr_req_addr, wr_req_data,
        input  sram_rdata,
        output rd_req_ready, rd_resp_valid, rd_resp_data,
        output wr_req_ready,
        output sram_en, sram_wmode, sram_addr, sram_wdata,
        output init_done
    );

    modport master (
        output rd_req_valid, rd_req_addr,
        output wr_req_valid, wr_req_addr, wr_req_data,
        output sram_rdata,
        input  rd_req_ready, rd_resp_valid, rd_resp_data,
        input  wr_req_ready,
        input  sram_en, sram_wmode, sram_addr, sram_wdata,
        input  init_done
    );
endinterface

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: single-port SRAM front-end. Arbitrates one reader and one writer onto
// the RW port with write priority and bounded read starvation, and returns read data
// one cycle after the grant, holding it until the next response.
// Optional feature: define SRAM_ARB_INIT_EN to zero-fill the array after reset.
module sram_rw_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    sram_rw_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH must equal 2**ADDR_W");
    end
    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be >= 1");
    end

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q;
    logic              init_done_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] hold_q;
    logic [CntW-1:0]   starve_cnt_q;
`ifdef SRAM_ARB_INIT_EN
    logic [ADDR_W-1:0] sweep_addr_q;
`endif

    logic run;
    logic read_wins;
    logic rd_grant;
    logic wr_grant;

    // Reset is synchronous, so outputs are gated with it to read as idle in every reset cycle.
    assign run       = (state_q == StRun) && !reset;
    assign read_wins = (starve_cnt_q == CntW'(STARVE_LIMIT));

    // A ready is offered whenever that requester would win, even if it is not valid.
    assign bus.wr_req_ready = run && !(bus.rd_req_valid && read_wins);
    assign bus.rd_req_ready = run && !(bus.wr_req_valid && !read_wins);
    assign wr_grant         = bus.wr_req_valid && bus.wr_req_ready;
    assign rd_grant         = bus.rd_req_valid && bus.rd_req_ready;

    assign bus.init_done     = init_done_q && !reset;
    assign bus.rd_resp_valid = resp_valid_q && !reset;
    assign bus.rd_resp_data  = bus.rd_resp_valid ? bus.sram_rdata : hold_q;

    // State machine: INIT (optional zero sweep) then RUN until the next reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StInit;
            init_done_q  <= 1'b0;
`ifdef SRAM_ARB_INIT_EN
            sweep_addr_q <= '0;
`endif
        end else begin
            case (state_q)
                StInit: begin
`ifdef SRAM_ARB_INIT_EN
                    sweep_addr_q <= sweep_addr_q + ADDR_W'(1);
                    if (sweep_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
`else
                    state_q     <= StRun;
                    init_done_q <= 1'b1;
`endif
                end
                StRun: begin
                    state_q     <= StRun;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= StInit;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Count reads blocked by a winning write; any read grant clears the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (rd_grant) begin
            starve_cnt_q <= '0;
        end else if (wr_grant && bus.rd_req_valid && !read_wins) begin
            starve_cnt_q <= starve_cnt_q + CntW'(1);
        end
    end

    // Response pulse follows a read grant; its data is kept in the hold register afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            resp_valid_q <= rd_grant;
            if (resp_valid_q) begin
                hold_q <= bus.sram_rdata;
            end
        end
    end

    // Macro drive: granted write, else granted read, else the init sweep write, else idle.
    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_wmode = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
`ifdef SRAM_ARB_INIT_EN
        if ((state_q == StInit) && !reset) begin
            bus.sram_en    = 1'b1;
            bus.sram_wmode = 1'b1;
            bus.sram_addr  = sweep_addr_q;
        end
`endif
        if (wr_grant) begin
            bus.sram_en    = 1'b1;
            bus.sram_wmode = 1'b1;
            bus.sram_addr  = bus.wr_req_addr;
            bus.sram_wdata = bus.wr_req_data;
        end else if (rd_grant) begin
            bus.sram_en    = 1'b1;
            bus.sram_addr  = bus.rd_req_addr;
        end
    end
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// tb_sram_rw_arbiter: directed bench for sram_rw_arbiter with a behavioural 1024x512 macro.
// Inputs change just after each falling edge; outputs are sampled 1 time unit later.
module tb_sram_rw_arbiter;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 512;
`ifdef SRAM_ARB_INIT_EN
    localparam int InitCycles = 1024;
`else
    localparam int InitCycles = 1;
`endif

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    logic [DATA_W-1:0] mem [0:1023];

    sram_rw_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_rw_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (1024),
        .STARVE_LIMIT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Macro model: one RW port, registered read.
    always @(posedge clock) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) mem[bus.sram_addr] <= bus.sram_wdata;
            else                bus.sram_rdata <= mem[bus.sram_addr];
        end
    end

    task automatic clear_inputs;
        bus.rd_req_valid = 1'b0;
        bus.wr_req_valid = 1'b0;
        bus.rd_req_addr  = '0;
        bus.wr_req_addr  = '0;
        bus.wr_req_data  = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.rd_req_valid = 1'b1;
        bus.wr_req_valid = 1'b1;
        @(negedge clock);
        @(negedge clock); #1;
        tests++;
        if (bus.rd_req_ready !== 1'b0 || bus.wr_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: rd=%b wr=%b required 0 0", bus.rd_req_ready, bus.wr_req_ready);
        end
        tests++;
        if (bus.rd_resp_valid !== 1'b0 || bus.init_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: resp_valid=%b init_done=%b required 0 0",
                     bus.rd_resp_valid, bus.init_done);
        end
        tests++;
        if (bus.sram_en !== 1'b0 || bus.sram_wmode !== 1'b0) begin
            fails++;
            $display("FAIL reset_sram: en=%b wmode=%b required 0 0", bus.sram_en, bus.sram_wmode);
        end
        tests++;
        if (bus.rd_resp_data !== '0 || dut.starve_cnt_q !== '0) begin
            fails++;
            $display("FAIL reset_regs: data=%h starve=%0d required 0 0",
                     bus.rd_resp_data, dut.starve_cnt_q);
        end
        clear_inputs();
    endtask

    task automatic test_init;
        int bad;
        bad = 0;
        @(negedge clock);
        reset = 1'b0; #1;
`ifdef SRAM_ARB_INIT_EN
        for (int i = 0; i < 1024; i++) begin
            if (!(bus.sram_en === 1'b1 && bus.sram_wmode === 1'b1 && bus.sram_addr === 10'(i) &&
                  bus.sram_wdata === '0 && bus.init_done === 1'b0 && bus.wr_req_ready === 1'b0))
                bad++;
            @(negedge clock); #1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL init_sweep: %0d bad sweep cycles, required 0", bad);
        end
        tests++;
        if (bus.init_done !== 1'b1 || bus.sram_en !== 1'b0) begin
            fails++;
            $display("FAIL init_done_1024: init_done=%b en=%b required 1 0", bus.init_done, bus.sram_en);
        end
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = 10'd5;
        @(negedge clock);
        bus.rd_req_valid = 1'b0; #1;
        tests++;
        if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== '0) begin
            fails++;
            $display("FAIL init_read5: valid=%b data=%h required 1 0", bus.rd_resp_valid, bus.rd_resp_data);
        end
`else
        tests++;
        if (bus.sram_en !== 1'b0 || bus.init_done !== 1'b0 || bus.wr_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL init_idle: en=%b init_done=%b wr_ready=%b required 0 0 0",
                     bus.sram_en, bus.init_done, bus.wr_req_ready);
        end
        @(negedge clock); #1;
        tests++;
        if (bus.init_done !== 1'b1 || bus.sram_en !== 1'b0) begin
            fails++;
            $display("FAIL init_done_1: init_done=%b en=%b required 1 0", bus.init_done, bus.sram_en);
        end
`endif
        bad = 0;
    endtask

    task automatic test_write_read;
        logic [DATA_W-1:0] pat;
        pat = {64{8'hA5}};
        @(negedge clock);
        bus.wr_req_valid = 1'b1;
        bus.wr_req_addr  = 10'h3FF;
        bus.wr_req_data  = pat; #1;
        tests++;
        if (!(bus.wr_req_ready === 1'b1 && bus.sram_en === 1'b1 && bus.sram_wmode === 1'b1 &&
              bus.sram_addr === 10'h3FF && bus.sram_wdata === pat)) begin
            fails++;
            $display("FAIL wr_grant: ready=%b en=%b wmode=%b addr=%h required 1 1 1 3ff",
                     bus.wr_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr);
        end
        @(negedge clock);
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = 10'h3FF; #1;
        tests++;
        if (!(bus.rd_req_ready === 1'b1 && bus.sram_en === 1'b1 && bus.sram_wmode === 1'b0 &&
              bus.sram_addr === 10'h3FF)) begin
            fails++;
            $display("FAIL rd_grant: ready=%b en=%b wmode=%b addr=%h required 1 1 0 3ff",
                     bus.rd_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr);
        end
        @(negedge clock);
        bus.rd_req_valid = 1'b0; #1;
        tests++;
        if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== pat) begin
            fails++;
            $display("FAIL raw_resp: valid=%b data=%h required 1 %h", bus.rd_resp_valid,
                     bus.rd_resp_data[31:0], pat[31:0]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            tests++;
            if (bus.rd_resp_valid !== 1'b0 || bus.rd_resp_data !== pat) begin
                fails++;
                $display("FAIL hold_%0d: valid=%b data=%h required 0 %h", i, bus.rd_resp_valid,
                         bus.rd_resp_data[31:0], pat[31:0]);
            end
        end
    endtask

    task automatic test_contention;
        logic exp_r;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            bus.wr_req_valid = 1'b1;
            bus.wr_req_addr  = 10'h010;
            bus.wr_req_data  = {64{8'h5A}};
            bus.rd_req_valid = 1'b1;
            bus.rd_req_addr  = 10'h3FF; #1;
            exp_r = ((k % 5) == 4);
            tests++;
            if (bus.rd_req_ready !== exp_r || bus.wr_req_ready !== !exp_r ||
                bus.sram_wmode !== !exp_r) begin
                fails++;
                $display("FAIL contend_%0d: rd_ready=%b wr_ready=%b wmode=%b required %b %b %b", k,
                         bus.rd_req_ready, bus.wr_req_ready, bus.sram_wmode, exp_r, !exp_r, !exp_r);
            end
            if (k == 4 || k == 5) begin
                tests++;
                if (dut.starve_cnt_q !== ((k == 4) ? 3'd4 : 3'd0)) begin
                    fails++;
                    $display("FAIL starve_cnt_%0d: %0d required %0d", k, dut.starve_cnt_q,
                             (k == 4) ? 4 : 0);
                end
            end
            if (k == 5) begin
                tests++;
                if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== {64{8'hA5}}) begin
                    fails++;
                    $display("FAIL contend_resp: valid=%b data=%h required 1 a5a5a5a5",
                             bus.rd_resp_valid, bus.rd_resp_data[31:0]);
                end
            end
        end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] v [3];
        v[0] = {64{8'h11}};
        v[1] = {64{8'h22}};
        v[2] = {64{8'h33}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.wr_req_valid = 1'b1;
            bus.wr_req_addr  = 10'(i + 1);
            bus.wr_req_data  = v[i];
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.wr_req_valid = 1'b0;
            bus.rd_req_valid = (i < 3);
            bus.rd_req_addr  = 10'(i + 1); #1;
            if (i > 0) begin
                tests++;
                if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== v[i-1]) begin
                    fails++;
                    $display("FAIL b2b_%0d: valid=%b data=%h required 1 %h", i, bus.rd_resp_valid,
                             bus.rd_resp_data[31:0], v[i-1][31:0]);
                end
            end
        end
        @(negedge clock); #1;
        tests++;
        if (bus.rd_resp_valid !== 1'b0 || bus.rd_resp_data !== v[2]) begin
            fails++;
            $display("FAIL b2b_hold: valid=%b data=%h required 0 %h", bus.rd_resp_valid,
                     bus.rd_resp_data[31:0], v[2][31:0]);
        end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clock);
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = 10'd1; #1;
        tests++;
        if (bus.rd_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_grant: rd_ready=%b required 1", bus.rd_req_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        bus.wr_req_valid = 1'b1; #1;
        tests++;
        if (bus.rd_resp_valid !== 1'b0 || bus.rd_req_ready !== 1'b0 || bus.wr_req_ready !== 1'b0 ||
            bus.sram_en !== 1'b0) begin
            fails++;
            $display("FAIL midrst_c1: resp=%b rd_ready=%b wr_ready=%b en=%b required 0 0 0 0",
                     bus.rd_resp_valid, bus.rd_req_ready, bus.wr_req_ready, bus.sram_en);
        end
        @(negedge clock); #1;
        tests++;
        if (bus.rd_resp_valid !== 1'b0 || bus.rd_resp_data !== '0 || bus.init_done !== 1'b0 ||
            bus.sram_en !== 1'b0 || bus.wr_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrst_c2: resp=%b data=%h init_done=%b en=%b required 0 0 0 0",
                     bus.rd_resp_valid, bus.rd_resp_data[31:0], bus.init_done, bus.sram_en);
        end
    endtask

    task automatic test_request_during_init;
        int cyc;
        int bad;
        cyc = 0;
        bad = 0;
        @(negedge clock);
        reset = 1'b0;
        bus.rd_req_valid = 1'b0;
        bus.wr_req_valid = 1'b1;
        bus.wr_req_addr  = 10'h123;
        bus.wr_req_data  = {64{8'hC3}}; #1;
`ifdef SRAM_ARB_INIT_EN
        tests++;
        if (bus.sram_en !== 1'b1 || bus.sram_wmode !== 1'b1 || bus.sram_addr !== 10'h000) begin
            fails++;
            $display("FAIL sweep_restart: en=%b wmode=%b addr=%h required 1 1 000",
                     bus.sram_en, bus.sram_wmode, bus.sram_addr);
        end
`endif
        while (bus.init_done !== 1'b1 && cyc < 2000) begin
            if (bus.wr_req_ready !== 1'b0) bad++;
            @(negedge clock); #1;
            cyc++;
        end
        tests++;
        if (bad != 0 || cyc != InitCycles) begin
            fails++;
            $display("FAIL init_wait: early_ready=%0d cycles=%0d required 0 %0d", bad, cyc, InitCycles);
        end
        tests++;
        if (!(bus.wr_req_ready === 1'b1 && bus.sram_en === 1'b1 && bus.sram_wmode === 1'b1 &&
              bus.sram_addr === 10'h123)) begin
            fails++;
            $display("FAIL init_first_grant: ready=%b en=%b wmode=%b addr=%h required 1 1 1 123",
                     bus.wr_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr);
        end
        @(negedge clock);
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = 10'h123;
        @(negedge clock);
        bus.rd_req_valid = 1'b0; #1;
        tests++;
        if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== {64{8'hC3}}) begin
            fails++;
            $display("FAIL init_req_data: valid=%b data=%h required 1 c3c3c3c3",
                     bus.rd_resp_valid, bus.rd_resp_data[31:0]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_init();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_request_during_init();
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
